// File: rtl/simd_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simd_alu_arbiter
// Purpose  : Round-robin arbiter that shares one external combinational
//            4-lane x 32-bit SIMD ALU among NUM_REQ requesters. The winner's
//            operands are registered into the ALU. The ALU result is
//            registered and returned with the requester ID through a
//            valid/ready response port that tolerates backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module simd_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_op,
    input  logic [128*NUM_REQ-1:0] req_a,
    input  logic [128*NUM_REQ-1:0] req_b,
    output logic [127:0]           alu_a,
    output logic [127:0]           alu_b,
    output logic [3:0]             alu_op,
    input  logic [127:0]           alu_result,
    input  logic                   alu_zero,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [127:0]           resp_result,
    output logic                   resp_zero,
    output logic                   resp_err,
    output logic                   busy
);

    // Highest legal op code (srl); everything above it is reported as illegal.
    localparam logic [3:0] C_OP_MAX_LEGAL = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_last;   // index of the last requester granted
    logic [ID_W-1:0]   r_id;     // owner of the operation in flight

    logic              w_hi_found;
    logic [ID_W-1:0]   w_hi_idx;
    logic              w_lo_found;
    logic [ID_W-1:0]   w_lo_idx;
    logic [ID_W-1:0]   w_win_idx;
    logic              w_grant;
    logic [3:0]        w_sel_op;
    logic [127:0]      w_sel_a;
    logic [127:0]      w_sel_b;
    logic              w_illegal;

    // Round-robin pick: first valid index above r_last, else first valid index
    // at or below it (the wrap-around), then one-hot grant and operand mux.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (i > int'(r_last)) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_idx   = ID_W'(i);
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = ID_W'(i);
                end
            end
        end
        w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;

        // A grant is possible from IDLE, or from RESP in the cycle the
        // pending response is accepted; never while reset is asserted.
        w_grant = rst_n && (|req_valid) &&
                  ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));

        req_ready = '0;
        w_sel_op  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(w_win_idx)) begin
                req_ready[i] = w_grant;
                w_sel_op     = req_op[4*i +: 4];
                w_sel_a      = req_a[128*i +: 128];
                w_sel_b      = req_b[128*i +: 128];
            end
        end
    end

    // Illegal ops are decided on the registered op so the ALU output is ignored.
    assign w_illegal = (alu_op > C_OP_MAX_LEGAL);

    assign busy = (r_state != S_IDLE);

    // Control FSM plus operand, ID and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                alu_a  <= w_sel_a;
                alu_b  <= w_sel_b;
                alu_op <= w_sel_op;
                r_id   <= w_win_idx;
                r_last <= w_win_idx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_valid  <= 1'b1;
                    resp_id     <= r_id;
                    resp_err    <= w_illegal;
                    resp_result <= w_illegal ? '0 : alu_result;
                    resp_zero   <= w_illegal | alu_zero;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= w_grant ? S_EXEC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simd_alu_arbiter
// Purpose  : Directed self-checking bench for simd_alu_arbiter. Provides a
//            behavioural SIMD ALU, drives requesters, and compares responses
//            against a scoreboard of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simd_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [1:0]   id;
        logic [127:0] res;
        logic         zero;
        logic         err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [4*NUM_REQ-1:0]   req_op;
    logic [128*NUM_REQ-1:0] req_a;
    logic [128*NUM_REQ-1:0] req_b;
    logic [127:0]           alu_a;
    logic [127:0]           alu_b;
    logic [3:0]             alu_op;
    logic [127:0]           alu_result;
    logic                   alu_zero;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [127:0]           resp_result;
    logic                   resp_zero;
    logic                   resp_err;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    exp_t         sb[$];
    logic [3:0]   op_s[NUM_REQ];
    logic [127:0] a_s[NUM_REQ];
    logic [127:0] b_s[NUM_REQ];

    simd_alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference SIMD ALU; illegal ops yield all ones so leakage is visible.
    function automatic logic [127:0] ref_alu(input logic [3:0] op,
                                             input logic [127:0] a,
                                             input logic [127:0] b);
        logic [127:0] r;
        logic [31:0]  x;
        logic [31:0]  y;
        r = '1;
        for (int l = 0; l < 4; l++) begin
            x = a[32*l +: 32];
            y = b[32*l +: 32];
            case (op)
                4'd0:    r[32*l +: 32] = x + y;
                4'd1:    r[32*l +: 32] = x - y;
                4'd2:    r[32*l +: 32] = x & y;
                4'd3:    r[32*l +: 32] = x | y;
                4'd4:    r[32*l +: 32] = x ^ y;
                4'd5:    r[32*l +: 32] = x << y[4:0];
                4'd6:    r[32*l +: 32] = x >> y[4:0];
                default: r[32*l +: 32] = 32'hFFFF_FFFF;
            endcase
        end
        return r;
    endfunction

    // Environment ALU driven from the DUT's registered operands.
    always_comb begin
        alu_result = ref_alu(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result[31:0] == 32'd0);
    end

    function automatic exp_t exp_of(input int i);
        exp_t e;
        e.id = 2'(i);
        if (op_s[i] > 4'd6) begin
            e.res  = '0;
            e.zero = 1'b1;
            e.err  = 1'b1;
        end else begin
            e.res  = ref_alu(op_s[i], a_s[i], b_s[i]);
            e.zero = (e.res[31:0] == 32'd0);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [127:0] lanes(input logic [31:0] l3, input logic [31:0] l2,
                                           input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op,
                           input logic [127:0] a, input logic [127:0] b);
        op_s[i] = op;
        a_s[i]  = a;
        b_s[i]  = b;
        req_op[4*i +: 4]     = op;
        req_a[128*i +: 128]  = a;
        req_b[128*i +: 128]  = b;
        req_valid[i]         = 1'b1;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic push_exp(input int i);
        sb.push_back(exp_of(i));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: every accepted response must match the scoreboard head.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 128'(resp_valid), 128'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_id",     128'(resp_id),     128'(e.id));
                chk("resp_result", resp_result,       e.res);
                chk("resp_zero",   128'(resp_zero),   128'(e.zero));
                chk("resp_err",    128'(resp_err),    128'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t bp;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // ---- reset values (a valid request must not be granted in reset)
        @(negedge clk);
        req_valid[0] = 1'b1;
        #1;
        chk("rst_req_ready",   128'(req_ready),  128'd0);
        chk("rst_resp_valid",  128'(resp_valid), 128'd0);
        chk("rst_busy",        128'(busy),       128'd0);
        chk("rst_resp_result", resp_result,      128'd0);
        chk("rst_resp_zero",   128'(resp_zero),  128'd0);
        chk("rst_resp_err",    128'(resp_err),   128'd0);
        chk("rst_resp_id",     128'(resp_id),    128'd0);
        chk("rst_alu_a",       alu_a,            128'd0);
        chk("rst_alu_b",       alu_b,            128'd0);
        chk("rst_alu_op",      128'(alu_op),     128'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- basic add
        @(negedge clk);
        set_req(0, 4'd0, lanes(4, 3, 2, 1), lanes(40, 30, 20, 10));
        #1;
        chk("add_grant", 128'(req_ready), 128'b0001);
        push_exp(0);
        @(negedge clk);
        clr_req(0);
        #1;
        chk("add_exec_busy",  128'(busy),      128'd1);
        chk("add_exec_ready", 128'(req_ready), 128'd0);
        chk("add_alu_a",      alu_a,           lanes(4, 3, 2, 1));
        chk("add_alu_op",     128'(alu_op),    128'd0);
        @(negedge clk);
        #1;
        chk("add_resp_valid",  128'(resp_valid), 128'd1);
        chk("add_resp_result", resp_result,      lanes(44, 33, 22, 11));
        chk("add_resp_id",     128'(resp_id),    128'd0);
        @(negedge clk);
        #1;
        chk("add_done_valid", 128'(resp_valid), 128'd0);
        chk("add_done_busy",  128'(busy),       128'd0);

        // ---- arbitration fairness: all four requesting continuously
        do_reset();
        set_req(0, 4'd0, lanes($urandom, $urandom, $urandom, $urandom), lanes($urandom, $urandom, $urandom, $urandom));
        set_req(1, 4'd1, lanes($urandom, $urandom, $urandom, $urandom), lanes($urandom, $urandom, $urandom, $urandom));
        set_req(2, 4'd4, lanes($urandom, $urandom, $urandom, $urandom), lanes($urandom, $urandom, $urandom, $urandom));
        set_req(3, 4'd5, lanes($urandom, $urandom, $urandom, $urandom), lanes($urandom, $urandom, $urandom, $urandom));
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("fair_grant", 128'(req_ready), 128'(4'b0001 << (g % 4)));
            push_exp(g % 4);
            @(negedge clk);
            if (g == 4) req_valid = '0;
            #1;
            chk("fair_gap", 128'(req_ready), 128'd0);
            @(negedge clk);
        end

        // ---- wrap-around after a grant to requester 3
        @(negedge clk);
        set_req(3, 4'd6, lanes(32'h8000_0000, 256, 64, 7), lanes(31, 4, 2, 1));
        #1;
        chk("wrap_grant3", 128'(req_ready), 128'b1000);
        push_exp(3);
        @(negedge clk);
        clr_req(3);
        @(negedge clk);
        set_req(0, 4'd2, lanes(32'hF0F0_F0F0, 1, 2, 3), lanes(32'h0FF0_0FF0, 3, 3, 3));
        set_req(3, 4'd3, lanes(1, 2, 4, 8), lanes(16, 32, 64, 128));
        #1;
        chk("wrap_grant0", 128'(req_ready), 128'b0001);
        push_exp(0);
        @(negedge clk);
        clr_req(0);
        clr_req(3);
        set_req(2, 4'd4, lanes(5, 6, 7, 8), lanes(8, 7, 6, 5));
        #1;
        chk("wrap_exec_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
        #1;
        chk("wrap_grant2", 128'(req_ready), 128'b0100);
        push_exp(2);
        @(negedge clk);
        clr_req(2);
        @(negedge clk);

        // ---- backpressure: response held while req1 waits
        @(negedge clk);
        resp_ready = 1'b0;
        set_req(0, 4'd3, lanes(1, 2, 3, 4), lanes(16, 32, 48, 64));
        #1;
        chk("bp_grant0", 128'(req_ready), 128'b0001);
        push_exp(0);
        bp = exp_of(0);
        @(negedge clk);
        clr_req(0);
        set_req(1, 4'd2, lanes(32'hFFFF_0000, 9, 9, 9), lanes(32'h00FF_FF00, 3, 5, 12));
        #1;
        chk("bp_exec_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_stall_ready",  128'(req_ready),  128'd0);
            chk("bp_stall_valid",  128'(resp_valid), 128'd1);
            chk("bp_stall_result", resp_result,      bp.res);
            chk("bp_stall_id",     128'(resp_id),    128'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_grant1", 128'(req_ready), 128'b0010);
        push_exp(1);
        @(negedge clk);
        clr_req(1);
        @(negedge clk);
        @(negedge clk);

        // ---- flags: zero lane 0 from sub, then an illegal op back-to-back
        set_req(2, 4'd1, lanes(7, 8, 9, 5), lanes(1, 2, 3, 5));
        #1;
        chk("flag_grant2", 128'(req_ready), 128'b0100);
        push_exp(2);
        @(negedge clk);
        clr_req(2);
        @(negedge clk);
        set_req(3, 4'b1000, lanes(11, 22, 33, 44), lanes(1, 1, 1, 1));
        #1;
        chk("flag_sub_zero", 128'(resp_zero),  128'd1);
        chk("flag_sub_err",  128'(resp_err),   128'd0);
        chk("flag_grant3",   128'(req_ready),  128'b1000);
        sb.push_back('{id: 2'd3, res: 128'd0, zero: 1'b1, err: 1'b1});
        @(negedge clk);
        clr_req(3);
        @(negedge clk);
        #1;
        chk("illegal_result", resp_result,     128'd0);
        chk("illegal_zero",   128'(resp_zero), 128'd1);
        chk("illegal_err",    128'(resp_err),  128'd1);
        chk("illegal_id",     128'(resp_id),   128'd3);
        @(negedge clk);

        // ---- asynchronous reset pulse while in EXEC
        set_req(0, 4'd0, lanes(1, 1, 1, 1), lanes(2, 2, 2, 2));
        #1;
        chk("rmid_grant0", 128'(req_ready), 128'b0001);
        @(negedge clk);
        clr_req(0);
        #1;
        chk("rmid_exec_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_resp_valid", 128'(resp_valid), 128'd0);
        chk("rmid_busy",       128'(busy),       128'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 4'd4, lanes(3, 3, 3, 3), lanes(1, 2, 3, 4));
        set_req(1, 4'd5, lanes(1, 1, 1, 1), lanes(1, 2, 3, 4));
        #1;
        chk("rmid_no_resp", 128'(resp_valid), 128'd0);
        chk("rmid_grant0_after", 128'(req_ready), 128'b0001);
        push_exp(0);
        @(negedge clk);
        clr_req(0);
        #1;
        chk("rmid_exec_ready", 128'(req_ready), 128'd0);
        @(negedge clk);
        #1;
        chk("rmid_grant1_after", 128'(req_ready), 128'b0010);
        push_exp(1);
        @(negedge clk);
        clr_req(1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("end_busy",     128'(busy),      128'd0);
        chk("end_sb_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simd_alu_arbiter.md
# simd_alu_arbiter

- Shares one combinational 128-bit, 4-lane SIMD ALU between NUM_REQ requesters.
- Each requester presents an op and two 128-bit operands through a valid/ready handshake; the block arbitrates among them round-robin.
- The winner's operands are registered into the ALU. The result is registered and returned with the requester ID through a valid/ready response port that tolerates backpressure.
- The block sits between the vector issue logic and the ALU datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester ID, equals clog2(NUM_REQ)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_op  in  4*NUM_REQ  op per requester; requester i uses bits [4i+3:4i]
- req_a  in  128*NUM_REQ  operand A per requester; requester i uses [128i+127:128i]
- req_b  in  128*NUM_REQ  operand B per requester, same packing as req_a
- alu_a  out  128  registered operand A to ALU
- alu_b  out  128  registered operand B to ALU
- alu_op  out  4  registered op to ALU
- alu_result  in  128  ALU result, combinational from alu_a/alu_b/alu_op
- alu_zero  in  1  ALU flag: lane-0 result (bits [31:0]) equals 0
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  index of the requester that owns the response
- resp_result  out  128  registered result
- resp_zero  out  1  registered zero flag
- resp_err  out  1  op code was illegal
- busy  out  1  state is not IDLE

## Operation
- **Op encoding (per 32-bit lane):**
  - 0 = add; 1 = sub; 2 = and; 3 = or; 4 = xor.
  - 5 = sll by b[4:0] of the lane; 6 = srl by b[4:0] of the lane.
  - 7..15 are illegal.
- **State IDLE:**
  - If any req_valid is set, the round-robin winner w gets req_ready[w]=1 in the same cycle.
  - On that edge: alu_a, alu_b and alu_op are loaded from requester w, an ID register is loaded with w, and the state goes to EXEC.
- **State EXEC:**
  - req_ready is all 0.
  - On the edge: resp_result and resp_zero capture alu_result and alu_zero, resp_id takes the ID register, resp_valid goes to 1, and the state goes to RESP.
  - Illegal op: resp_result=0, resp_zero=1, resp_err=1. The ALU outputs are ignored.
- **State RESP:**
  - Response outputs are held stable while resp_ready=0, and req_ready is all 0.
  - On resp_ready=1 the response completes and resp_valid drops. In the same cycle:
    - if any req_valid is set, the winner is granted and captured exactly as in IDLE, and the state goes to EXEC;
    - otherwise the state goes to IDLE.
- **Round-robin arbitration:**
  - Pointer `last` holds the index of the last requester granted.
  - Search order is last+1, last+2, ... modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - `last` updates only on a grant.
- **req_ready rules:**
  - req_ready depends combinationally on req_valid, state and resp_ready.
  - req_ready is never asserted to a requester whose req_valid is 0.
- **Requester obligations:** a requester holds req_valid, op and operands stable until it sees req_ready. A requester may drop req_valid before it is granted; it then has no grant pending.
- **Operand-register updates:** alu_a, alu_b and alu_op change only on a grant.

## Timing
- **Reset values** (immediately on rst_n low, independent of clk):
  - state = IDLE; last = NUM_REQ-1, so requester 0 has priority first.
  - req_ready = 0; resp_valid = 0; busy = 0.
  - resp_result = 0; resp_zero = 0; resp_err = 0; resp_id = 0.
  - alu_a = 0; alu_b = 0; alu_op = 0.
- **Reset mid-operation:** any in-flight op is dropped with no response.
- **Latency:** grant in cycle T gives resp_valid=1 in cycle T+2.
- **Throughput:** with resp_ready held at 1, there is one grant every 2 cycles.
- **Back-to-back:** a response handshake and a new grant in the same cycle are legal. The next resp_valid follows 2 cycles later.
- **No re-grant during a stall:** while resp_valid=1 and resp_ready=0, no new grant is made.
- **busy:** equals 1 in EXEC and in RESP.

## Test plan
- **Basic add:**
  - Stimulus: req0 only, op=0, a lanes {4,3,2,1}, b lanes {40,30,20,10}, resp_ready=1.
  - Response: req_ready[0] high in cycle T; resp_valid in T+2 with lanes {44,33,22,11}, resp_id=0, resp_zero=0, resp_err=0.
- **Arbitration fairness:**
  - Stimulus: all 4 requesters valid from the first cycle after reset, each keeps requesting after it is served, resp_ready=1.
  - Response: grants in order 0,1,2,3,0, spaced 2 cycles apart; resp_id follows the same order.
- **Wrap-around:**
  - Stimulus: after a grant to 3, raise req0 and req3 together.
  - Response: 0 wins. With only req2 then valid, 2 wins next.
- **Backpressure:**
  - Stimulus: hold resp_ready=0 for 5 cycles with req1 valid.
  - Response: response outputs frozen, req_ready all 0. In the cycle resp_ready rises, req_ready[1]=1 and the response completes.
- **Flags:**
  - sub with a=b=0x00000005 in lane 0 and other lanes nonzero-different → resp_zero=1.
  - Illegal op 4'b1000 → resp_result=0, resp_zero=1, resp_err=1.
- **Reset mid-EXEC:**
  - Stimulus: pulse rst_n low between two clk edges while in EXEC.
  - Response: resp_valid=0 and busy=0 at once, with no response afterwards. After release with req0 and req1 valid, req0 is granted first.
